// File: rtl/twos_comp_serial_decoder_if.sv
// Handshake bundle between the serial link, the two's-complement decoder and the parallel datapath.
// The master side drives the serial bits and the output acceptance; the slave side is the decoder.
interface twos_comp_serial_decoder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [WIDTH-1:0] out_mag;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_sign, out_mag
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_sign, out_mag
  );
endinterface

// File: rtl/twos_comp_serial_decoder.sv
// Bit-serial two's-complement receiver: collects WIDTH bits LSB first and presents sign plus magnitude.
// The magnitude of negative words is formed on the fly by the copy-through-first-one, invert-after rule.
module twos_comp_serial_decoder #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  twos_comp_serial_decoder_if.slave bus
);

  localparam int               CNT_W      = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(WIDTH - 1);
  localparam logic [0:0]       ST_COLLECT = 1'b0;
  localparam logic [0:0]       ST_HOLD    = 1'b1;

  logic [0:0]       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             seen_one_r;
  logic [WIDTH-1:0] raw_sr_r;
  logic [WIDTH-1:0] neg_sr_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             out_sign_r;
  logic [WIDTH-1:0] out_mag_r;

  logic             accept_s;
  logic             nb_s;
  logic             last_bit_s;
  logic [WIDTH-1:0] raw_next_s;
  logic [WIDTH-1:0] neg_next_s;

  // Next shift-register contents, including the bit arriving this cycle
  always_comb begin
    accept_s   = bus.in_valid & in_ready_r;
    nb_s       = seen_one_r ? ~bus.in_bit : bus.in_bit;
    raw_next_s = {bus.in_bit, raw_sr_r[WIDTH-1:1]};
    neg_next_s = {nb_s, neg_sr_r[WIDTH-1:1]};
    last_bit_s = (cnt_r == LAST_CNT);
  end

  // Word collection, on-the-fly negation and output hand-off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_COLLECT;
      cnt_r       <= {CNT_W{1'b0}};
      seen_one_r  <= 1'b0;
      raw_sr_r    <= {WIDTH{1'b0}};
      neg_sr_r    <= {WIDTH{1'b0}};
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_sign_r  <= 1'b0;
      out_mag_r   <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_COLLECT: begin
          // in_ready only comes up on the first edge after reset release
          if (!in_ready_r) begin
            in_ready_r <= 1'b1;
          end else if (accept_s) begin
            raw_sr_r <= raw_next_s;
            neg_sr_r <= neg_next_s;
            if (last_bit_s) begin
              out_sign_r  <= bus.in_bit;
              out_mag_r   <= bus.in_bit ? neg_next_s : raw_next_s;
              out_valid_r <= 1'b1;
              in_ready_r  <= 1'b0;
              cnt_r       <= {CNT_W{1'b0}};
              seen_one_r  <= 1'b0;
              state_r     <= ST_HOLD;
            end else begin
              seen_one_r <= seen_one_r | bus.in_bit;
              cnt_r      <= cnt_r + CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_COLLECT;
          end
        end
        default: begin
          state_r     <= ST_COLLECT;
          cnt_r       <= {CNT_W{1'b0}};
          seen_one_r  <= 1'b0;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sign  = out_sign_r;
  assign bus.out_mag   = out_mag_r;

endmodule
